// File: rtl/adc_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : adc_share_sched
// Brief    : Round-robin sharing of one serial 8-channel 12-bit ADC between
//            N_REQ requesters, with priming frames for the ADC's one-frame lag.
// Revision : 1.0 - initial release
// ============================================================================
module adc_share_sched #(
    parameter int N_REQ    = 3,
    parameter int HALF_DIV = 10
) (
    input  logic               clk_50,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [3*N_REQ-1:0] req_ch,
    output logic [N_REQ-1:0]   ack,
    output logic [11:0]        res_data,
    output logic               busy,
    output logic               adc_cs_n,
    output logic               adc_sck,
    output logic               din,
    input  logic               dout
);

    localparam int RR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SUM_W  = RR_W + 1;
    localparam int IDX2_W = (N_REQ > 1) ? $clog2(2 * N_REQ) : 1;
    localparam int CNT_W  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         bit_q, bit_d;
    logic               cs_n_q, cs_n_d;
    logic               sck_q, sck_d;
    logic               din_q, din_d;
    logic [11:0]        shreg_q, shreg_d;
    logic [11:0]        res_q, res_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               busy_q, busy_d;
    logic [RR_W-1:0]    rr_q, rr_d;
    logic [RR_W-1:0]    gnt_q, gnt_d;
    logic [2:0]         gch_q, gch_d;
    logic [2:0]         last_addr_q, last_addr_d;
    logic               addr_valid_q, addr_valid_d;
    logic               prime_q, prime_d;

    logic [2*N_REQ-1:0] w_req2;
    logic [IDX2_W-1:0]  w_rr_ext;
    logic [N_REQ-1:0]   w_rot;
    logic               w_found;
    logic [RR_W-1:0]    w_off;
    logic [SUM_W-1:0]   w_sum;
    logic [RR_W-1:0]    w_gnt;
    logic [2:0]         w_gch;
    logic [RR_W-1:0]    w_rr_next;
    logic               w_cnt_done;

    // Address bits 2..4 carry the channel MSB-first; every other bit is zero.
    function automatic logic din_bit(input logic [3:0] b, input logic [2:0] ch);
        if (b == 4'd2) return ch[2];
        if (b == 4'd3) return ch[1];
        if (b == 4'd4) return ch[0];
        return 1'b0;
    endfunction

    // Rotate requests so the search always starts at rr, then map back.
    assign w_req2   = {req, req};
    assign w_rr_ext = IDX2_W'(rr_q);
    assign w_rot    = w_req2[w_rr_ext +: N_REQ];

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_off   = RR_W'(i);
            end
        end
    end

    assign w_sum = SUM_W'(rr_q) + SUM_W'(w_off);
    assign w_gnt = (w_sum >= SUM_W'(N_REQ)) ? RR_W'(w_sum - SUM_W'(N_REQ)) : RR_W'(w_sum);

    always_comb begin
        w_gch = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt == RR_W'(i)) begin
                w_gch = req_ch[3*i +: 3];
            end
        end
    end

    assign w_rr_next  = (gnt_q == RR_W'(N_REQ - 1)) ? '0 : gnt_q + RR_W'(1);
    assign w_cnt_done = (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        cs_n_d       = cs_n_q;
        sck_d        = sck_q;
        din_d        = din_q;
        shreg_d      = shreg_q;
        res_d        = res_q;
        ack_d        = '0;
        busy_d       = busy_q;
        rr_d         = rr_q;
        gnt_d        = gnt_q;
        gch_d        = gch_q;
        last_addr_d  = last_addr_q;
        addr_valid_d = addr_valid_q;
        prime_d      = prime_q;

        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    gnt_d   = w_gnt;
                    gch_d   = w_gch;
                    prime_d = !(addr_valid_q && (last_addr_q == w_gch));
                end
            end

            ST_SETUP: begin
                if (w_cnt_done) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    sck_d   = 1'b0;
                    din_d   = din_bit(4'd0, gch_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SHIFT: begin
                if (!w_cnt_done) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        // Rising sck edge: the ADC has held dout since the fall.
                        sck_d = 1'b1;
                        if (bit_q >= 4'd4) begin
                            shreg_d = {shreg_q[10:0], dout};
                        end
                    end else if (bit_q == 4'd15) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        sck_d = 1'b0;
                        din_d = din_bit(bit_q + 4'd1, gch_q);
                    end
                end
            end

            ST_HOLD: begin
                if (w_cnt_done) begin
                    state_d      = ST_GAP;
                    cnt_d        = '0;
                    cs_n_d       = 1'b1;
                    din_d        = 1'b0;
                    last_addr_d  = gch_q;
                    addr_valid_d = 1'b1;
                    if (!prime_q) begin
                        res_d = shreg_q;
                        rr_d  = w_rr_next;
                        for (int i = 0; i < N_REQ; i++) begin
                            ack_d[i] = (gnt_q == RR_W'(i));
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (!prime_q && (cnt_q == '0)) begin
                    busy_d = 1'b0;
                end
                if (w_cnt_done) begin
                    cnt_d = '0;
                    if (prime_q) begin
                        prime_d = 1'b0;
                        state_d = ST_SETUP;
                        cs_n_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                sck_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= 4'd0;
            cs_n_q       <= 1'b1;
            sck_q        <= 1'b1;
            din_q        <= 1'b0;
            shreg_q      <= '0;
            res_q        <= '0;
            ack_q        <= '0;
            busy_q       <= 1'b0;
            rr_q         <= '0;
            gnt_q        <= '0;
            gch_q        <= '0;
            last_addr_q  <= '0;
            addr_valid_q <= 1'b0;
            prime_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            cs_n_q       <= cs_n_d;
            sck_q        <= sck_d;
            din_q        <= din_d;
            shreg_q      <= shreg_d;
            res_q        <= res_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            gch_q        <= gch_d;
            last_addr_q  <= last_addr_d;
            addr_valid_q <= addr_valid_d;
            prime_q      <= prime_d;
        end
    end

    assign ack      = ack_q;
    assign res_data = res_q;
    assign busy     = busy_q;
    assign adc_cs_n = cs_n_q;
    assign adc_sck  = sck_q;
    assign din      = din_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_share_sched
// Brief    : Bench for adc_share_sched with a lagging-ADC model and a
//            transaction-level scheduler reference.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adc_share_sched;

    localparam int N = 3;
    localparam int H = 10;

    logic           clk_50 = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [3*N-1:0] req_ch;
    logic [N-1:0]   ack;
    logic [11:0]    res_data;
    logic           busy;
    logic           adc_cs_n;
    logic           adc_sck;
    logic           din;
    logic           dout;

    adc_share_sched #(.N_REQ(N), .HALF_DIV(H)) dut (
        .clk_50   (clk_50),
        .rst_n    (rst_n),
        .req      (req),
        .req_ch   (req_ch),
        .ack      (ack),
        .res_data (res_data),
        .busy     (busy),
        .adc_cs_n (adc_cs_n),
        .adc_sck  (adc_sck),
        .din      (din),
        .dout     (dout)
    );

    always #10 clk_50 = ~clk_50;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Edge-sampled view of what the DUT saw
    int             cyc = 0;
    logic [N-1:0]   req_snap = '0;
    logic [3*N-1:0] ch_snap = '0;
    logic           rst_seen = 1'b0;

    always @(posedge clk_50) begin
        cyc      <= cyc + 1;
        req_snap <= req;
        ch_snap  <= req_ch;
        rst_seen <= !rst_n;
    end

    // ADC model: returns the channel addressed in the previous frame
    logic [2:0]  adc_addr = 3'd0;
    logic [11:0] chan_val [8];
    bit          rand_vals = 1'b0;
    int          a_fall = 0, a_rise = 0;
    logic [15:0] a_din = '0;
    logic [2:0]  f_src = '0;
    logic [15:0] f_stream = '0;
    bit          pend = 1'b0;
    int          pend_bit = 0;
    logic [11:0] last_word = '0;
    logic [2:0]  last_src = '0;
    int          fall0_cyc = 0, sck_per = 0;
    logic        cs_prev = 1'b1, sck_prev = 1'b1;
    bit          mon_en = 1'b0;

    // Scheduler reference: transaction-level arbitration and latency
    int          m_rr = 0;
    logic [2:0]  m_last = '0;
    bit          m_valid = 1'b0;
    bit          txn = 1'b0;
    int          t0c = 0, g_exp = 0, nfr = 0, mk = 0;
    logic [2:0]  ch_exp = '0;

    always @(negedge clk_50) begin
        if (mon_en) begin
            if (pend) begin
                dout = f_stream[4'(15 - pend_bit)];
                pend = 1'b0;
            end
            if (!adc_cs_n && cs_prev) begin
                a_fall = 0;
                a_rise = 0;
                a_din  = '0;
                f_src  = adc_addr;
                if (rand_vals) chan_val[f_src] = 12'($urandom);
                f_stream = {4'($urandom), chan_val[f_src]};
            end
            if (!adc_cs_n && sck_prev && !adc_sck) begin
                pend     = 1'b1;
                pend_bit = a_fall;
                if (a_fall == 0) fall0_cyc = cyc;
                else if (a_fall == 1) sck_per = cyc - fall0_cyc;
                a_fall++;
            end
            if (!adc_cs_n && !sck_prev && adc_sck && a_rise < 16) begin
                a_din[4'(15 - a_rise)] = din;
                a_rise++;
                if (a_rise == 5) adc_addr = a_din[13:11];
            end
            if (adc_cs_n && !cs_prev) begin
                pend = 1'b0;
                if (a_rise == 16) begin
                    chk("din_frame", a_din, {2'b00, ch_exp, 11'd0});
                    last_word = f_stream[11:0];
                    last_src  = f_src;
                end
            end
            if (adc_cs_n && cs_prev && !adc_sck) chk("sck_idle_high", adc_sck, 1'b1);

            if (rst_seen) begin
                m_rr    = 0;
                m_last  = '0;
                m_valid = 1'b0;
                txn     = 1'b0;
            end else begin
                if (!txn && cs_prev && !adc_cs_n) begin
                    g_exp = -1;
                    for (int i = 0; i < N; i++) begin
                        mk = (m_rr + i) % N;
                        if (g_exp < 0 && req_snap[mk]) g_exp = mk;
                    end
                    if (g_exp < 0) begin
                        chk("grant_without_req", 0, 1);
                        g_exp = 0;
                    end
                    ch_exp = ch_snap[3*g_exp +: 3];
                    nfr    = (m_valid && m_last == ch_exp) ? 1 : 2;
                    t0c    = cyc;
                    txn    = 1'b1;
                end
                if (ack != '0) begin
                    if (!txn) begin
                        chk("spurious_ack", ack, 0);
                    end else begin
                        chk("ack_onehot", ack, 32'(1) << g_exp);
                        chk("ack_latency", cyc - t0c, (nfr == 1) ? 34 * H : 69 * H);
                        chk("res_vs_adc", res_data, last_word);
                        chk("res_src_ch", last_src, ch_exp);
                        chk("busy_at_ack", busy, 1'b1);
                        m_rr    = (g_exp + 1) % N;
                        m_last  = ch_exp;
                        m_valid = 1'b1;
                        txn     = 1'b0;
                    end
                end
            end
        end
        cs_prev  = adc_cs_n;
        sck_prev = adc_sck;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic wait_ack(output int who, input int budget);
        who = -1;
        for (int i = 0; i < budget && who < 0; i++) begin
            @(negedge clk_50);
            for (int k = 0; k < N; k++) if (ack[k]) who = k;
        end
        if (who < 0) chk("ack_timeout", 0, 1);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        req   = '0;
        tick(n);
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs_n"}, adc_cs_n, 1'b1);
        chk({tag, "_sck"}, adc_sck, 1'b1);
        chk({tag, "_din"}, din, 1'b0);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int who;
        int c0;
        int exp_who [3];
        int exp_res [3];
        logic [N-1:0] pending;

        rst_n  = 1'b0;
        req    = '0;
        req_ch = '0;
        dout   = 1'b0;
        for (int c = 0; c < 8; c++) chan_val[c] = 12'(c * 100 + 7);

        do_reset(3);
        chk_reset_outputs("reset");
        chk("reset_res", res_data, 0);
        mon_en = 1'b1;

        // First transaction after reset: always primed
        chan_val[5]  = 12'h45E;
        req_ch[2:0]  = 3'd5;
        req[0]       = 1'b1;
        c0 = cyc;
        wait_ack(who, 1000);
        req[0] = 1'b0;
        chk("t1_who", who, 0);
        chk("t1_res", res_data, 1118);
        chk("t1_latency", cyc - c0, 691);
        chk("t1_sck_period", sck_per, 20);
        tick(1);
        chk("t1_busy_drop", busy, 1'b0);
        tick(15);

        // Same channel again: single frame; requester 2 leaves rr at 0
        chan_val[5]  = 12'h7CE;
        req_ch[8:6]  = 3'd5;
        req[2]       = 1'b1;
        c0 = cyc;
        wait_ack(who, 1000);
        req[2] = 1'b0;
        chk("t2_who", who, 2);
        chk("t2_res", res_data, 1998);
        chk("t2_latency", cyc - c0, 341);
        tick(15);

        // Three simultaneous requests on channels 5/6/7
        chan_val[6] = 12'd291;
        chan_val[7] = 12'd3802;
        req_ch = {3'd7, 3'd6, 3'd5};
        req    = 3'b111;
        exp_who = '{0, 1, 2};
        exp_res = '{1998, 291, 3802};
        for (int i = 0; i < 3; i++) begin
            wait_ack(who, 1000);
            chk("t3_who", who, exp_who[i]);
            chk("t3_res", res_data, exp_res[i]);
            if (who >= 0) req[who] = 1'b0;
        end
        req = '0;
        tick(15);

        // Requester 1 drops after grant; ack still comes and rr moves to 2
        chan_val[3] = 12'd1365;
        req_ch[5:3] = 3'd3;
        req[1] = 1'b1;
        tick(100);
        req[1] = 1'b0;
        wait_ack(who, 1000);
        chk("t4_who", who, 1);
        chk("t4_res", res_data, 1365);
        req_ch[2:0] = 3'd0;
        req_ch[8:6] = 3'd2;
        req[0] = 1'b1;
        req[2] = 1'b1;
        wait_ack(who, 1000);
        chk("t4_next_who", who, 2);
        if (who >= 0) req[who] = 1'b0;
        wait_ack(who, 1000);
        chk("t4_last_who", who, 0);
        req = '0;
        tick(20);

        // Fairness with two continuously held requests
        do_reset(1);
        req_ch[2:0] = 3'd1;
        req_ch[5:3] = 3'd1;
        req[1:0]    = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_ack(who, 1000);
            chk("rr_alternate", who, i % 2);
        end
        req = '0;
        tick(20);

        // Reset mid-SHIFT forces a primed frame even on the same channel
        req_ch[2:0] = 3'd4;
        req[0] = 1'b1;
        wait_ack(who, 1000);
        req[0] = 1'b0;
        tick(15);
        req[0] = 1'b1;
        tick(200);
        do_reset(1);
        chk_reset_outputs("midshift_rst");
        tick(5);
        req[0] = 1'b1;
        c0 = cyc;
        wait_ack(who, 1000);
        req[0] = 1'b0;
        chk("t5_who", who, 0);
        chk("t5_two_frames", cyc - c0, 691);
        tick(15);

        // Randomized traffic against the reference
        rand_vals = 1'b1;
        for (int it = 0; it < 20; it++) begin
            pending = N'($urandom_range(1, 7));
            for (int k = 0; k < N; k++) begin
                if (pending[k]) req_ch[3*k +: 3] = 3'($urandom_range(0, 7));
            end
            req = pending;
            while (pending != '0) begin
                wait_ack(who, 800);
                if (who < 0) break;
                req[who]     = 1'b0;
                pending[who] = 1'b0;
            end
            req = '0;
            tick($urandom_range(0, 25));
        end
        tick(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_share_sched.md
# adc_share_sched

Round-robin scheduler that shares the single serial 8-channel 12-bit ADC between N_REQ requesters. It owns the ADC pins (adc_cs_n, adc_sck, din, dout) and runs one conversion transaction per grant. The ADC returns data for the channel addressed in the *previous* frame, so the block tracks the last-addressed channel and inserts a priming frame when needed. It sits between the ADC pins and the consumer blocks, for example the line-sensor and battery monitors that previously used fixed channels 5, 6 and 7.

## Interface
- N_REQ, 3: number of requesters.
- HALF_DIV, 10: clk_50 cycles per adc_sck half-period (10 gives 2.5 MHz).
- clk_50 input 1: system clock, 50 MHz. Everything is clocked on its rising edge.
- rst_n input 1: synchronous, active-low reset.
- req input N_REQ: per-requester conversion request. Held high until its ack.
- req_ch input 3*N_REQ: channel for requester k on bits [3k+2:3k]. Stable while req[k] is high.
- ack output N_REQ: one-hot, one-cycle pulse. res_data is valid in that cycle.
- res_data output 12: last conversion result. Held until the next ack.
- busy output 1: high from frame start until the cycle after the final ack.
- adc_cs_n output 1: ADC chip select, active low.
- adc_sck output 1: ADC serial clock. Idles high.
- din output 1: serial address to the ADC.
- dout input 1: serial data from the ADC.

## Operation
- **States:** IDLE, SETUP, SHIFT, HOLD, GAP.
- **Arbitration (IDLE):**
  - Round-robin pointer rr starts at 0.
  - The first requester with req high, searching rr, rr+1, … mod N_REQ, is granted.
  - After requester g is acked, rr becomes (g+1) mod N_REQ.
  - A req that drops before it is granted is ignored.
  - A granted transaction always completes and always pulses ack, even if req drops mid-transaction.
- **Channel latch:** the granted channel gch is latched at grant and is used for the whole transaction.
- **Transaction length:**
  - If addr_valid=1 and last_addr==gch: one frame.
  - Otherwise: two frames. Frame 1 is a priming frame; its data is discarded and no ack is issued. Frame 2 delivers the result.
  - Both frames address gch.
- **Frame:**
  - adc_cs_n goes low, then 16 adc_sck periods run.
  - Bit i (0..15) is driven on din at the falling edge i.
  - din bits 2, 3 and 4 carry gch[2], gch[1] and gch[0]. All other din bits are 0.
  - dout is sampled on the clk_50 edge where adc_sck rises.
  - Samples for bits 4..15 are shifted in MSB-first to form D11..D0. Bits 0..3 are discarded.
- **After each frame:**
  - last_addr ← gch, addr_valid ← 1.
  - On the delivering frame, res_data ← the shifted word and ack[g] pulses.
- **GAP:** adc_cs_n stays high for HALF_DIV cycles. Then the block enters SETUP of frame 2, or returns to IDLE.
- **Reset values** (any cycle, including mid-frame):
  - adc_cs_n=1, adc_sck=1, din=0.
  - ack=0, res_data=0, busy=0.
  - rr=0, last_addr=0, addr_valid=0.
  - The state returns to IDLE.
  - The first transaction after reset is always two frames, because an aborted frame may have changed the ADC address.

## Timing
- Let t0 be the clk_50 edge at which IDLE sees a request. At t0, adc_cs_n ← 0 and busy ← 1.
- **SETUP:** adc_cs_n low, adc_sck high, HALF_DIV cycles.
- **SHIFT, per bit:**
  - adc_sck low for HALF_DIV cycles; din changes on the falling edge.
  - adc_sck high for HALF_DIV cycles.
  - Total 32·HALF_DIV cycles for the 16 bits.
- **HOLD:** adc_sck high, adc_cs_n low, HALF_DIV cycles.
- **Frame end:** adc_cs_n rises at t0+34·HALF_DIV. On a delivering frame, ack and res_data update on that same edge.
- **Latency:**
  - Single-frame ack at t0+34·HALF_DIV (340 cycles at default).
  - Two-frame ack at t0+69·HALF_DIV (690 cycles).
- **Next grant:** the earliest next t0 is ack+HALF_DIV+1 (after GAP, then IDLE evaluates).
- **adc_sck:** never toggles while adc_cs_n is high.
- **dout pin:** is not registered before sampling. The bench must change dout ≥1 cycle after the adc_sck falling edge.

## Test plan
- **Reset, then req[0]=1, ch=5, dout stream 0x045E per frame:**
  - Two frames; din frame = 0x2800.
  - ack[0] at t0+690.
  - res_data = 1118.
  - adc_sck period = 20 cycles.
- **Repeat req[0], ch=5 after the first ack:** single frame, ack at t0+340, res_data equal to the new dout word (e.g. 0x7CE → 1998).
- **req[0..2] all high simultaneously, channels 5/6/7, addr_valid=1 with last_addr=5:**
  - Grant order 0, 1, 2.
  - Requester 0 takes one frame; requesters 1 and 2 take two frames each.
  - Each ack carries its own dout word (3802 on ch7).
- **Round-robin fairness:**
  - req[0] and req[1] held high continuously.
  - Acks alternate 0, 1, 0, 1.
  - No requester gets two consecutive acks.
- **rst_n low for one cycle mid-SHIFT:**
  - Next cycle: adc_cs_n=1, adc_sck=1, ack=0, busy=0.
  - A following request on the previously addressed channel still takes two frames.
- **req[1] dropped after grant, before ack:** ack[1] still pulses and rr advances to 2.
